hack_cpu_param: RTL
===================

# hack_cpu_param

Parametrised Hack-architecture CPU core; successor to the fixed 16-bit core. Executes A- and C-instructions from instruction ROM via `prog_counter`, and uses speculative PC increment. Adds a configurable slow-memory window with programmable read latency, a `retired` pulse for performance counting, and optional single-step control. Sits between instruction ROM, data RAM/IO, and the VRAM arbiter that drives `mem_busy`.

## Interface
- `WIDTH`, default 16: data, address, instruction and PC width; must be ≥16.
- `SLOW_MASK`, default 16'h6000: an address is slow when `(addr & SLOW_MASK) == SLOW_BASE`.
- `SLOW_BASE`, default 16'h4000: slow-window match value.
- `READ_LAT`, default 2: cycles from `mem_busy` low to data valid for a slow read; must be ≥1.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `instruction`, in, WIDTH: ROM word at `prog_counter`.
- `mem_busy`, in, 1: slow region currently owned by another master.
- `mem_rdata`, in, WIDTH: data at `mem_address`.
- `mem_load`, out, 1: write strobe.
- `mem_address`, out, WIDTH: equals A register.
- `mem_wdata`, out, WIDTH: equals ALU output.
- `prog_counter`, out, WIDTH: ROM address (register).
- `retired`, out, 1: one-cycle pulse per completed instruction (register).
- `step`, in, 1: present only with `HACK_STEP_EN`.

## Operation
- Decode: `i`=instr[WIDTH-1], `a`=instr[12], comp=instr[11:6], dest d1/d2/d3=instr[5:3], jump j1/j2/j3=instr[2:0]. Bits [WIDTH-2:13] are ignored for C-instructions.
- ALU: standard Hack zx/nx/zy/ny/f/no over WIDTH bits, with x=D and y=(a ? M-latch : A). zero = (out==0); neg = out[WIDTH-1]; pos = !zero && !neg. A jump is taken when (j1&neg)|(j2&zero)|(j3&pos).
- States: FETCH, DECODE, WB, MEM_READ, MEM_FETCH.
  - FETCH → DECODE unconditionally.
  - DECODE:
    - A-instruction: A ← instruction with MSB forced 0; go to MEM_READ.
    - C-instruction: latch control fields; alu_x←D, alu_y←A or M-latch; go to WB.
    - Both cases: PC ← PC+1, wrapping at 2^WIDTH.
  - WB commit condition: `!d3 || !slow(A) || !mem_busy`. Otherwise hold WB with all state frozen.
    - On commit: d1 → A←alu; d2 → D←alu; d3 → M-latch←alu.
    - If the jump is taken, PC ← A value from before this write.
    - Next state: d1 set → MEM_READ (takes priority over jump); else jump taken → FETCH; else DECODE.
  - MEM_READ:
    - Fast address → MEM_FETCH next cycle.
    - Slow address: hold while `mem_busy`. After the first cycle with `mem_busy`=0, count READ_LAT cycles, ignoring `mem_busy` from then on, then go to MEM_FETCH.
  - MEM_FETCH: M-latch ← mem_rdata; wait counter ← 0; go to DECODE.
- `mem_load` = (state==WB) && d3. It stays high for every stalled WB cycle.
- `retired` ← 1 on any WB→{DECODE, FETCH, MEM_READ} commit, and on MEM_FETCH→DECODE when the instruction being completed was an A-instruction. Otherwise 0.

## Timing
- Reset values (cycle after reset sampled high): PC=0, A=0, D=0, M-latch=0, wait counter=0, state=FETCH, `mem_load`=0, `retired`=0, `mem_address`=0, `mem_wdata`=ALU of zeroed latches. Reset overrides every stall, including mid-slow-wait.
- Cycles per instruction with fast memory:
  - A-instruction: 3 (DECODE, MEM_READ, MEM_FETCH).
  - C-instruction, no d1, no jump: 2.
  - C-instruction with jump, no d1: 3 (includes FETCH).
  - C-instruction with d1: 4.
- Slow read adds (busy cycles) + READ_LAT cycles. Slow write adds one cycle per WB cycle with `mem_busy`=1.
- Simultaneous d1+d3 to a slow address: the stall condition uses the old A. Memory is written at old A, then the read is issued at new A.

## Configuration
- `HACK_STEP_EN` defined: `step` port exists. DECODE only executes (including the PC increment) in a cycle where `step`=1; otherwise the core holds in DECODE with no side effects. All other states ignore `step`.
- `HACK_STEP_EN` undefined: no `step` port; DECODE always executes.

## Test plan
- Reset, ROM[0]=0x0005 → `mem_address`=5 and PC=1 by DECODE exit; `retired` pulses once 3 cycles after the first DECODE.
- ROM: 0x0005, 0xEC10 (D=A), 0x0010, 0xE308 (M=D) → `mem_load`=1 for exactly 1 cycle with `mem_address`=0x10 and `mem_wdata`=5.
- A=0x0020, then 0xEA87 (0;JMP) → PC=0x20 after WB, then one FETCH cycle before DECODE.
- A=0x4000, 0xEE88 (M=-1), `mem_busy` high for 5 cycles → `mem_load` high 6 cycles; the write commits on the first cycle with busy low.
- A=0x4001 read with `mem_busy` high 3 cycles, `mem_rdata`=0xBEEF → MEM_FETCH entered exactly READ_LAT cycles after busy falls; M-latch=0xBEEF.
- Assert reset during a slow read wait → next cycle state=FETCH, PC=0, `retired`=0, `mem_load`=0.

Source files
------------

// File: rtl/hack_cpu_param.sv
// hack_cpu_param: parametrised Hack CPU core with a slow-memory window, retire pulse and optional single-step
// Ports: clk, reset (sync, active-high); instruction = ROM word at prog_counter;
//   mem_busy = slow window owned by another master; mem_rdata = data at mem_address;
//   mem_load = write strobe; mem_address = A; mem_wdata = ALU out; prog_counter = ROM address;
//   retired = one-cycle pulse per completed instruction; step (only with HACK_STEP_EN) gates DECODE.
module hack_cpu_param #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SLOW_MASK = 16'h6000,
  parameter logic [WIDTH-1:0] SLOW_BASE = 16'h4000,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic             mem_busy,
  input  logic [WIDTH-1:0] mem_rdata,
`ifdef HACK_STEP_EN
  input  logic             step,
`endif
  output logic             mem_load,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] prog_counter,
  output logic             retired
);
  localparam int CW = $clog2(READ_LAT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, WB, MEM_READ, MEM_FETCH} state_t;
  state_t state, next_state;
  logic [WIDTH-1:0] a_reg, d_reg, m_latch, alu_x, alu_y, alu_out;
  logic [WIDTH-1:0] x1, x2, y1, y2, sum_and;
  logic [5:0] comp;
  logic [2:0] dest, jmp;
  logic is_a, go, slow_a, commit, zr, ng, take, rd_done, rd_started;
  logic [CW-1:0] wcnt;
`ifdef HACK_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  assign x1 = comp[5] ? '0 : alu_x;
  assign x2 = comp[4] ? ~x1 : x1;
  assign y1 = comp[3] ? '0 : alu_y;
  assign y2 = comp[2] ? ~y1 : y1;
  assign sum_and = comp[1] ? x2 + y2 : x2 & y2;
  assign alu_out = comp[0] ? ~sum_and : sum_and;
  assign zr = alu_out == '0;
  assign ng = alu_out[WIDTH-1];
  assign take = |(jmp & {ng, zr, !zr && !ng});
  assign slow_a = (a_reg & SLOW_MASK) == SLOW_BASE;
  // the stall decision looks at the A value in effect before this WB commits
  assign commit = !dest[0] || !slow_a || !mem_busy;
  // once the window has been granted the latency count runs regardless of mem_busy
  assign rd_started = wcnt != '0 || !mem_busy;
  assign rd_done = !slow_a || (rd_started && wcnt == CW'(READ_LAT - 1));
  assign mem_address = a_reg;
  assign mem_wdata = alu_out;
  always_ff @(posedge clk)
    state <= reset ? FETCH : next_state;
  always_comb begin
    next_state = state;
    case (state)
      FETCH:     next_state = DECODE;
      DECODE:    next_state = !go ? DECODE : instruction[WIDTH-1] ? WB : MEM_READ;
      WB:        next_state = !commit ? WB : dest[2] ? MEM_READ : take ? FETCH : DECODE;
      MEM_READ:  next_state = rd_done ? MEM_FETCH : MEM_READ;
      MEM_FETCH: next_state = DECODE;
      default:   next_state = FETCH;
    endcase
  end
  always_comb mem_load = state == WB && dest[0];
  always_ff @(posedge clk)
    if (reset) begin
      prog_counter <= '0;
      a_reg <= '0;
      d_reg <= '0;
      m_latch <= '0;
      alu_x <= '0;
      alu_y <= '0;
      comp <= '0;
      dest <= '0;
      jmp <= '0;
      is_a <= 1'b0;
      wcnt <= '0;
      retired <= 1'b0;
    end else begin
      retired <= (state == WB && commit) || (state == MEM_FETCH && is_a);
      case (state)
        DECODE: if (go) begin
          prog_counter <= prog_counter + 1'b1;
          is_a <= !instruction[WIDTH-1];
          if (!instruction[WIDTH-1]) a_reg <= {1'b0, instruction[WIDTH-2:0]};
          else begin
            comp <= instruction[11:6];
            dest <= instruction[5:3];
            jmp <= instruction[2:0];
            alu_x <= d_reg;
            alu_y <= instruction[12] ? m_latch : a_reg;
          end
        end
        WB: if (commit) begin
          if (dest[2]) a_reg <= alu_out;
          if (dest[1]) d_reg <= alu_out;
          if (dest[0]) m_latch <= alu_out;
          if (take) prog_counter <= a_reg;
        end
        MEM_READ: if (slow_a && rd_started && !rd_done) wcnt <= wcnt + 1'b1;
        MEM_FETCH: begin
          m_latch <= mem_rdata;
          wcnt <= '0;
        end
        default: ;
      endcase
    end
endmodule
